// File: rtl/clock_cfg_pkg.sv
// Shared types, key codes and BCD limits for the keypad clock/alarm setting logic.
package clock_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    T_H1   = 4'd1,
    T_H0   = 4'd2,
    T_M1   = 4'd3,
    T_M0   = 4'd4,
    A_SLOT = 4'd5,
    A_H1   = 4'd6,
    A_H0   = 4'd7,
    A_M1   = 4'd8,
    A_M0   = 4'd9,
    C_SLOT = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    FLD_H1 = 2'd0,
    FLD_H0 = 2'd1,
    FLD_M1 = 2'd2,
    FLD_M0 = 2'd3
  } field_e;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] DIGIT_MAX            = 4'd9;
  localparam logic [3:0] HOUR_TENS_MAX        = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MIN_TENS_MAX         = 4'd5;

  // Range check of one BCD time digit; hour units depend on the staged hour tens.
  function automatic logic bcd_digit_ok(input field_e field, input logic [3:0] digit,
                                        input logic [3:0] staged_h1);
    logic ok;
    case (field)
      FLD_H1:  ok = (digit <= HOUR_TENS_MAX);
      FLD_H0:  ok = (staged_h1 == HOUR_TENS_MAX) ? (digit <= HOUR_UNITS_MAX_AT_20)
                                                 : (digit <= DIGIT_MAX);
      FLD_M1:  ok = (digit <= MIN_TENS_MAX);
      default: ok = (digit <= DIGIT_MAX);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/entry_timeout.sv
// Inactivity counter for entry sequences: reloads to zero, counts while running,
// flags expiry combinationally on the last count when not being reloaded.
module entry_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Saturates at the last count so a missed expiry can never wrap around.
  always_comb begin
    count_d = count_q;
    if (load_i)                          count_d = '0;
    else if (run_i && count_q != CNT_LAST) count_d = count_q + CNT_W'(1);
  end

  assign expire_c_o = run_i && !load_i && (count_q == CNT_LAST);

endmodule

// File: rtl/clock_setting_fsm.sv
// Keypad configuration controller: staged time entry, N alarm slots, cancel,
// BCD validation and inactivity timeout.
module clock_setting_fsm
  import clock_cfg_pkg::*;
#(
  parameter int unsigned N_ALARMS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter bit          TICK_EN_RST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_value,
  output logic                  time_load,
  output logic [7:0]            new_hour,
  output logic [7:0]            new_minute,
  output logic [8*N_ALARMS-1:0] alarm_hour,
  output logic [8*N_ALARMS-1:0] alarm_minute,
  output logic [N_ALARMS-1:0]   alarm_en,
  output logic                  tick_en,
  output logic                  entry_error,
  output logic [3:0]            state
);

  localparam int unsigned AW = 8 * N_ALARMS;

  state_e            state_q, state_d;
  logic [3:0]        h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, slot_q, slot_d;
  logic [7:0]        new_hour_q, new_hour_d, new_minute_q, new_minute_d;
  logic [AW-1:0]     alarm_hour_q, alarm_hour_d, alarm_minute_q, alarm_minute_d;
  logic [N_ALARMS-1:0] alarm_en_q, alarm_en_d;
  logic              tick_en_q, tick_en_d;
  logic              time_load_q, time_load_d;
  logic              entry_error_q, entry_error_d;

  logic   timeout_c, tmo_load_c, tmo_run_c;
  logic   digit_c, digit_ok_c, slot_ok_c, clear_stage_c;
  field_e field_c;

  assign tmo_load_c = key_valid || (state_q == IDLE);
  assign tmo_run_c  = (state_q != IDLE);

  entry_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmo_load_c),
    .run_i     (tmo_run_c),
    .expire_c_o(timeout_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      h1_q           <= '0;
      h0_q           <= '0;
      m1_q           <= '0;
      slot_q         <= '0;
      new_hour_q     <= '0;
      new_minute_q   <= '0;
      alarm_hour_q   <= '0;
      alarm_minute_q <= '0;
      alarm_en_q     <= '0;
      tick_en_q      <= TICK_EN_RST;
      time_load_q    <= 1'b0;
      entry_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      h1_q           <= h1_d;
      h0_q           <= h0_d;
      m1_q           <= m1_d;
      slot_q         <= slot_d;
      new_hour_q     <= new_hour_d;
      new_minute_q   <= new_minute_d;
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
      alarm_en_q     <= alarm_en_d;
      tick_en_q      <= tick_en_d;
      time_load_q    <= time_load_d;
      entry_error_q  <= entry_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    h1_d           = h1_q;
    h0_d           = h0_q;
    m1_d           = m1_q;
    slot_d         = slot_q;
    new_hour_d     = new_hour_q;
    new_minute_d   = new_minute_q;
    alarm_hour_d   = alarm_hour_q;
    alarm_minute_d = alarm_minute_q;
    alarm_en_d     = alarm_en_q;
    tick_en_d      = tick_en_q;
    time_load_d    = 1'b0;
    entry_error_d  = 1'b0;
    clear_stage_c  = 1'b0;

    digit_c   = (key_value <= DIGIT_MAX);
    slot_ok_c = digit_c && (32'(key_value) < N_ALARMS);
    case (state_q)
      T_H0, A_H0: field_c = FLD_H0;
      T_M1, A_M1: field_c = FLD_M1;
      T_M0, A_M0: field_c = FLD_M0;
      default:    field_c = FLD_H1;
    endcase
    digit_ok_c = digit_c && bcd_digit_ok(field_c, key_value, h1_q);

    if (key_valid) begin
      if (state_q == IDLE) begin
        case (key_value)
          KEY_A:        state_d = T_H1;
          KEY_B:        state_d = A_SLOT;
          KEY_C:        state_d = C_SLOT;
          KEY_D:        tick_en_d = ~tick_en_q;
          KEY_E, KEY_F: state_d = IDLE;
          default:      state_d = IDLE;
        endcase
      end else if (key_value == KEY_E) begin
        state_d       = IDLE;
        clear_stage_c = 1'b1;
      end else begin
        // Assume rejection; each accepting branch clears the error below.
        entry_error_d = 1'b1;
        case (state_q)
          A_SLOT: if (slot_ok_c) begin
            slot_d        = key_value;
            state_d       = A_H1;
            entry_error_d = 1'b0;
          end
          C_SLOT: if (slot_ok_c) begin
            for (int unsigned i = 0; i < N_ALARMS; i++)
              if (4'(i) == key_value) alarm_en_d[i] = 1'b0;
            state_d       = IDLE;
            clear_stage_c = 1'b1;
            entry_error_d = 1'b0;
          end
          T_H1, A_H1: if (digit_ok_c) begin
            h1_d          = key_value;
            state_d       = (state_q == T_H1) ? T_H0 : A_H0;
            entry_error_d = 1'b0;
          end
          T_H0, A_H0: if (digit_ok_c) begin
            h0_d          = key_value;
            state_d       = (state_q == T_H0) ? T_M1 : A_M1;
            entry_error_d = 1'b0;
          end
          T_M1, A_M1: if (digit_ok_c) begin
            m1_d          = key_value;
            state_d       = (state_q == T_M1) ? T_M0 : A_M0;
            entry_error_d = 1'b0;
          end
          T_M0: if (digit_ok_c) begin
            new_hour_d    = {h1_q, h0_q};
            new_minute_d  = {m1_q, key_value};
            time_load_d   = 1'b1;
            state_d       = IDLE;
            clear_stage_c = 1'b1;
            entry_error_d = 1'b0;
          end
          A_M0: if (digit_ok_c) begin
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
              if (4'(i) == slot_q) begin
                alarm_hour_d[8*i +: 8]   = {h1_q, h0_q};
                alarm_minute_d[8*i +: 8] = {m1_q, key_value};
                alarm_en_d[i]            = 1'b1;
              end
            end
            state_d       = IDLE;
            clear_stage_c = 1'b1;
            entry_error_d = 1'b0;
          end
          default: entry_error_d = 1'b0;
        endcase
      end
    end else if (timeout_c) begin
      state_d       = IDLE;
      clear_stage_c = 1'b1;
    end

    if (clear_stage_c) begin
      h1_d   = '0;
      h0_d   = '0;
      m1_d   = '0;
      slot_d = '0;
    end
  end

  assign time_load    = time_load_q;
  assign new_hour     = new_hour_q;
  assign new_minute   = new_minute_q;
  assign alarm_hour   = alarm_hour_q;
  assign alarm_minute = alarm_minute_q;
  assign alarm_en     = alarm_en_q;
  assign tick_en      = tick_en_q;
  assign entry_error  = entry_error_q;
  assign state        = state_q;

endmodule

// File: tb/tb_clock_setting_fsm.sv
// Scoreboard bench: a key-level reference model pushes the expected outputs for
// every driven cycle; a negedge monitor pops and compares them.
module tb_clock_setting_fsm;
  import clock_cfg_pkg::*;

  localparam int unsigned NA = 4;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst, key_valid;
  logic [3:0]      key_value;
  logic            time_load, tick_en, entry_error;
  logic [7:0]      new_hour, new_minute;
  logic [8*NA-1:0] alarm_hour, alarm_minute;
  logic [NA-1:0]   alarm_en;
  logic [3:0]      state;

  always #5 clk = ~clk;

  clock_setting_fsm #(
    .N_ALARMS      (NA),
    .TIMEOUT_CYCLES(TO),
    .TICK_EN_RST   (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_value   (key_value),
    .time_load   (time_load),
    .new_hour    (new_hour),
    .new_minute  (new_minute),
    .alarm_hour  (alarm_hour),
    .alarm_minute(alarm_minute),
    .alarm_en    (alarm_en),
    .tick_en     (tick_en),
    .entry_error (entry_error),
    .state       (state)
  );

  typedef struct {
    logic [3:0]      st;
    logic [7:0]      nh, nm;
    logic [8*NA-1:0] ah, am;
    logic [NA-1:0]   en;
    logic            tick, tl, err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: mode 0 idle, 1 time entry, 2 alarm entry, 3 clear slot.
  int         m_mode, m_pos, m_idle;
  int         m_dig[5];
  logic [7:0] m_nh, m_nm;
  logic [7:0] m_ah[NA];
  logic [7:0] m_am[NA];
  logic       m_en[NA];
  logic       m_tick, m_tl, m_err;

  task automatic discard();
    m_mode = 0;
    m_pos  = 0;
  endtask

  task automatic model_reset();
    discard();
    m_idle = 0;
    for (int i = 0; i < 5; i++) m_dig[i] = 0;
    m_nh = '0;
    m_nm = '0;
    for (int i = 0; i < NA; i++) begin
      m_ah[i] = '0;
      m_am[i] = '0;
      m_en[i] = 1'b0;
    end
    m_tick = 1'b1;
  endtask

  task automatic model_key(input int k);
    int  base, f, s;
    bit  ok;
    logic [7:0] hh, mm;
    m_idle = 0;
    if (m_mode == 0) begin
      case (k)
        10: begin m_mode = 1; m_pos = 0; end
        11: begin m_mode = 2; m_pos = 0; end
        12: m_mode = 3;
        13: m_tick = !m_tick;
        default: ;
      endcase
    end else if (k == 14) begin
      discard();
    end else if (k > 9) begin
      m_err = 1'b1;
    end else if (m_mode == 3) begin
      if (k < int'(NA)) begin m_en[k] = 1'b0; discard(); end
      else m_err = 1'b1;
    end else if (m_mode == 2 && m_pos == 0) begin
      if (k < int'(NA)) begin m_dig[0] = k; m_pos = 1; end
      else m_err = 1'b1;
    end else begin
      base = (m_mode == 2) ? 1 : 0;
      f    = m_pos - base;
      // A digit is legal if some completion of the field still gives hour<=23, minute<=59.
      case (f)
        0:       ok = (k * 10 <= 23);
        1:       ok = (m_dig[base] * 10 + k <= 23);
        2:       ok = (k * 10 <= 59);
        default: ok = 1'b1;
      endcase
      if (!ok) begin
        m_err = 1'b1;
      end else begin
        m_dig[base + f] = k;
        m_pos++;
        if (f == 3) begin
          hh = 8'(m_dig[base] * 16 + m_dig[base + 1]);
          mm = 8'(m_dig[base + 2] * 16 + m_dig[base + 3]);
          if (m_mode == 1) begin
            m_nh = hh;
            m_nm = mm;
            m_tl = 1'b1;
          end else begin
            s = m_dig[0];
            m_ah[s] = hh;
            m_am[s] = mm;
            m_en[s] = 1'b1;
          end
          discard();
        end
      end
    end
  endtask

  task automatic model_idle();
    if (m_mode != 0) begin
      m_idle++;
      if (m_idle >= int'(TO)) discard();
    end
  endtask

  function automatic state_e exp_state();
    state_e s;
    s = IDLE;
    case (m_mode)
      1: case (m_pos)
           0: s = T_H1; 1: s = T_H0; 2: s = T_M1; default: s = T_M0;
         endcase
      2: case (m_pos)
           0: s = A_SLOT; 1: s = A_H1; 2: s = A_H0; 3: s = A_M1; default: s = A_M0;
         endcase
      3: s = C_SLOT;
      default: s = IDLE;
    endcase
    return s;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.st   = exp_state();
    e.nh   = m_nh;
    e.nm   = m_nm;
    for (int i = 0; i < NA; i++) begin
      e.ah[8*i +: 8] = m_ah[i];
      e.am[8*i +: 8] = m_am[i];
      e.en[i]        = m_en[i];
    end
    e.tick = m_tick;
    e.tl   = m_tl;
    e.err  = m_err;
    return e;
  endfunction

  // One clock cycle of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic drive(input logic r, input logic v, input logic [3:0] k);
    exp_t e;
    rst       = r;
    key_valid = v;
    key_value = k;
    m_tl  = 1'b0;
    m_err = 1'b0;
    if (r)      model_reset();
    else if (v) model_key(int'(k));
    else        model_idle();
    e = snapshot();
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    rst       = 1'b0;
    key_valid = 1'b0;
    key_value = 4'($urandom_range(0, 15));
  endtask

  task automatic key(input logic [3:0] k);
    drive(1'b0, 1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic keys(input logic [3:0] ks[$]);
    foreach (ks[i]) key(ks[i]);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("state",        64'(state),        64'(mon_e.st));
      chk("time_load",    64'(time_load),    64'(mon_e.tl));
      chk("entry_error",  64'(entry_error),  64'(mon_e.err));
      chk("new_hour",     64'(new_hour),     64'(mon_e.nh));
      chk("new_minute",   64'(new_minute),   64'(mon_e.nm));
      chk("alarm_hour",   64'(alarm_hour),   64'(mon_e.ah));
      chk("alarm_minute", 64'(alarm_minute), 64'(mon_e.am));
      chk("alarm_en",     64'(alarm_en),     64'(mon_e.en));
      chk("tick_en",      64'(tick_en),      64'(mon_e.tick));
    end
  end

  initial begin
    int r;
    logic [3:0] k;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_value = '0;
    model_reset();

    drive(1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b1, 4'hA);

    keys('{4'hA, 4'h1, 4'h2, 4'h3, 4'h4});
    idle(2);
    keys('{4'hA, 4'h2, 4'h4, 4'h3, 4'h5, 4'h9});
    idle(1);
    keys('{4'hB, 4'h3, 4'h0, 4'h7, 4'h3, 4'h0});
    keys('{4'hB, 4'h4, 4'hE});
    keys('{4'hC, 4'h3});
    idle(1);

    // Key on the expiry cycle wins; then a full idle window times out.
    keys('{4'hA, 4'h1});
    idle(15);
    key(4'h2);
    idle(17);

    keys('{4'hA, 4'h1, 4'hE, 4'hD, 4'hD, 4'hF, 4'h5});
    keys('{4'hA, 4'hB, 4'h9, 4'hE});
    keys('{4'hB, 4'h0, 4'h1, 4'h2});
    drive(1'b1, 1'b1, 4'h5);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (r < 4) begin
        idle(int'($urandom_range(14, 18)));
      end else if (r < 40) begin
        idle(1);
      end else begin
        if (r < 70)      k = 4'($urandom_range(0, 3));
        else if (r < 85) k = 4'($urandom_range(0, 9));
        else             k = 4'($urandom_range(10, 15));
        key(k);
      end
    end
    idle(2);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clock_setting_fsm.md
Name: clock_setting_fsm

Overview:
- Keypad-driven configuration controller for the wall-clock design; sits between the debounced keypad decoder and the timekeeping/alarm-compare logic.
- Generalises the single-alarm setting FSM to N_ALARMS alarm slots.
- Adds staged (atomic) commits, BCD range validation, a cancel key and an inactivity timeout.

Parameters:
- N_ALARMS, 4, number of alarm slots (1..10; each slot selected by one digit key).
- TIMEOUT_CYCLES, 10000000, idle cycles inside an entry sequence before it is abandoned (>=2).
- TICK_EN_RST, 1, reset value of tick_en.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_valid  in  1  one-cycle strobe, key_value is valid
- key_value  in  4  0-9 digit, A set time, B set alarm, C clear alarm, D toggle tick, E cancel, F ignored
- time_load  out  1  one-cycle pulse; new_hour/new_minute hold a freshly committed time
- new_hour  out  8  BCD hour {tens,units}
- new_minute  out  8  BCD minute
- alarm_hour  out  8*N_ALARMS  BCD hour per slot; slot i at [8i+7:8i]
- alarm_minute  out  8*N_ALARMS  BCD minute per slot
- alarm_en  out  N_ALARMS  per-slot armed flag
- tick_en  out  1  ticking-sound enable
- entry_error  out  1  one-cycle pulse on a rejected key
- state  out  4  current FSM state encoding, for the display

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, time_load=0, entry_error=0, new_hour=new_minute=0, all alarm_hour/alarm_minute=0, alarm_en=0, tick_en=TICK_EN_RST, staging registers=0, timeout counter=0.
- Keys take effect only when key_valid=1. Outputs update on the clk edge after the strobe (latency 1).
- States: IDLE, T_H1, T_H0, T_M1, T_M0, A_SLOT, A_H1, A_H0, A_M1, A_M0, C_SLOT. Encodings live in the package.
- IDLE transitions:
  - A -> T_H1.
  - B -> A_SLOT.
  - C -> C_SLOT.
  - D -> toggle tick_en.
  - Digits, E and F -> no action, no error.
- Time entry: T_H1 -> T_H0 -> T_M1 -> T_M0. Each accepted digit goes into a staging register.
  - On the accepted T_M0 digit: new_hour and new_minute load together, time_load pulses for one cycle, state returns to IDLE.
  - new_* never changes mid-sequence.
- Alarm entry:
  - A_SLOT: accepts digit d < N_ALARMS, latches slot=d.
  - Then A_H1..A_M0. On the final accepted digit, slot d's hour and minute load together, alarm_en[d]=1, state returns to IDLE.
  - Re-setting an armed slot overwrites it.
- C_SLOT: digit d < N_ALARMS -> alarm_en[d]=0, state returns to IDLE. Slot time values are retained.
- Digit validation. A digit is rejected if it fails the check for its field:
  - H1: must be <=2.
  - H0: if H1==2, must be <=3; otherwise <=9.
  - M1: must be <=5.
  - M0: must be <=9.
  - Slot: must be < N_ALARMS.
- A rejected digit pulses entry_error, leaves state and staging unchanged, and reloads the timeout.
- A non-digit key (A-D, F) inside any entry state also pulses entry_error and is otherwise ignored.
- E in any non-IDLE state -> IDLE, staged data discarded, outputs unchanged, no error.
- Timeout:
  - The counter reloads to 0 on entering a non-IDLE state and on every key_valid.
  - It increments each cycle while in a non-IDLE state.
  - When it reaches TIMEOUT_CYCLES-1 with no key that cycle, the FSM goes to IDLE and discards staged data.
  - A key arriving in the same cycle as expiry wins: it is processed and the counter reloads.
- time_load and entry_error are never high in the same cycle.
- Reset mid-sequence: the staged sequence is discarded and every output takes its reset value.

Decomposition:
- Package clock_cfg_pkg holds:
  - state encodings;
  - key code constants KEY_A..KEY_F;
  - BCD limit constants (HOUR_TENS_MAX=2, HOUR_UNITS_MAX_AT_20=3, MIN_TENS_MAX=5);
  - function bcd_digit_ok(field, digit, staged_h1).
- One sub-module: entry_timeout, a loadable counter with expire pulse, parameter TIMEOUT_CYCLES. The counter width is derived with $clog2.

Test Plan:
- Reset, then keys A,1,2,3,4 -> one time_load pulse; new_hour=8'h12, new_minute=8'h34; state=IDLE; new_* unchanged until the 4th digit.
- Keys A,2,4 -> entry_error pulse on the digit 4, state stays T_H0; then 3,5,9 -> new_hour=8'h23, new_minute=8'h59.
- N_ALARMS=4, keys B,3,0,7,3,0 -> alarm_en=4'b1000, slot3 hour=8'h07, minute=8'h30. Then B,4 -> entry_error, state stays A_SLOT. Then C,3 -> alarm_en=4'b0000, slot3 values retained.
- TIMEOUT_CYCLES=16, keys A,1 then idle -> IDLE exactly 16 cycles after the last key; new_hour unchanged. Key arriving on the expiry cycle -> processed, no timeout.
- Keys A,1,E -> IDLE, no time_load. D twice -> tick_en 1->0->1. Assert rst during A_M1 -> all outputs at reset values next cycle.
